// File: rtl/i2c_reg_master.sv
// I2C register-access master: START, address, write stream, optional repeated-start read, STOP.
// Quarter-bit timing engine with clock-stretch support; lines are open-drain (1 = release).
module i2c_reg_master #(
   parameter int unsigned CLK_FREQ = 25_000_000,
   parameter int unsigned I2C_FREQ = 100_000,
   parameter int unsigned LEN_W    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [6:0]       i_addr,
   input  logic [LEN_W-1:0] i_wlen,
   input  logic [LEN_W-1:0] i_rlen,
   input  logic [7:0]       i_wdata,
   input  logic             i_wvalid,
   output logic             o_wready,
   output logic [7:0]       o_rdata,
   output logic             o_rvalid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_nack,
   output logic             o_scl,
   output logic             o_sda,
   input  logic             i_scl,
   input  logic             i_sda
);

   localparam int unsigned QDivRaw = CLK_FREQ / I2C_FREQ / 4;
   localparam int unsigned QDiv    = (QDivRaw < 1) ? 1 : QDivRaw;
   localparam int unsigned QW      = (QDiv > 1) ? $clog2(QDiv) : 1;
   localparam logic [QW-1:0]    QLast  = QW'(QDiv - 1);
   localparam logic [QW-1:0]    QOne   = QW'(1);
   localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

   typedef enum logic [3:0] {
      StIdle, StStart, StAddr, StAddrAck, StWaitWr, StWrite, StWriteAck,
      StRstart, StRead, StReadAck, StStop
   } state_e;

   state_e           state_q, state_d;
   logic [QW-1:0]    qcnt_q, qcnt_d;
   logic [1:0]       phase_q, phase_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [6:0]       addr_q, addr_d;
   logic             rd_q, rd_d;
   logic [LEN_W-1:0] wcnt_q, wcnt_d;
   logic [LEN_W-1:0] rcnt_q, rcnt_d;
   logic             sample_q, sample_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             done_q, done_d;
   logic             nack_q, nack_d;
   logic             scl_q, scl_d;
   logic             sda_q, sda_d;
   logic [1:0]       scl_sync_q;
   logic [1:0]       sda_sync_q;

   logic scl_in, sda_in, run, stretch, tick, bit_end, sample_pt;

   // Bus pins are asynchronous to i_clk; two-flop synchronisers before use.
   assign scl_in = scl_sync_q[1];
   assign sda_in = sda_sync_q[1];

   assign run       = (state_q != StIdle) && (state_q != StWaitWr);
   assign stretch   = scl_q && !scl_in;
   assign tick      = run && !stretch && (qcnt_q == QLast);
   assign sample_pt = tick && (phase_q == 2'd2);
   assign bit_end   = tick && (phase_q == 2'd3);

   always_comb begin
      qcnt_d  = qcnt_q;
      phase_d = phase_q;
      if (!run) begin
         qcnt_d  = '0;
         phase_d = 2'd0;
      end else if (stretch || tick) begin
         // A stretched quarter restarts from zero so SCL high time is a full quarter.
         qcnt_d = '0;
         if (tick) phase_d = phase_q + 2'd1;
      end else begin
         qcnt_d = qcnt_q + QOne;
      end
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      wcnt_d   = wcnt_q;
      rcnt_d   = rcnt_q;
      sample_d = sample_pt ? sda_in : sample_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
      nack_d   = nack_q;
      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d = StStart;
               addr_d  = i_addr;
               wcnt_d  = i_wlen;
               rcnt_d  = i_rlen;
               nack_d  = 1'b0;
               rd_d    = (i_wlen == '0) && (i_rlen != '0);
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StAddr;
               shift_d = {addr_q, rd_q};
               bit_d   = 3'd7;
            end
         end
         StAddr, StWrite: begin
            if (bit_end) begin
               if (bit_q == 3'd0) begin
                  state_d = (state_q == StAddr) ? StAddrAck : StWriteAck;
               end else begin
                  bit_d   = bit_q - 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
               end
            end
         end
         StAddrAck: begin
            if (bit_end) begin
               if (sample_q) begin
                  nack_d  = 1'b1;
                  state_d = StStop;
               end else if (rd_q) begin
                  state_d = StRead;
                  bit_d   = 3'd7;
               end else if (wcnt_q != '0) begin
                  state_d = StWaitWr;
               end else begin
                  state_d = StStop;
               end
            end
         end
         StWaitWr: begin
            if (i_wvalid) begin
               state_d = StWrite;
               shift_d = i_wdata;
               bit_d   = 3'd7;
               wcnt_d  = wcnt_q - LenOne;
            end
         end
         StWriteAck: begin
            if (bit_end) begin
               if (sample_q) begin
                  nack_d  = 1'b1;
                  state_d = StStop;
               end else if (wcnt_q != '0) begin
                  state_d = StWaitWr;
               end else if (rcnt_q != '0) begin
                  state_d = StRstart;
                  rd_d    = 1'b1;
               end else begin
                  state_d = StStop;
               end
            end
         end
         StRstart: begin
            if (bit_end) begin
               state_d = StAddr;
               shift_d = {addr_q, 1'b1};
               bit_d   = 3'd7;
            end
         end
         StRead: begin
            if (sample_pt) shift_d = {shift_q[6:0], sda_in};
            if (bit_end) begin
               if (bit_q == 3'd0) begin
                  rdata_d  = shift_q;
                  rvalid_d = 1'b1;
                  rcnt_d   = rcnt_q - LenOne;
                  state_d  = StReadAck;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end
         end
         StReadAck: begin
            if (bit_end) begin
               if (rcnt_q == '0) begin
                  state_d = StStop;
               end else begin
                  state_d = StRead;
                  bit_d   = 3'd7;
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Line levels are decoded from next-state values and registered, so pins never glitch.
   always_comb begin
      logic scl_bit;
      scl_bit = (phase_d == 2'd1) || (phase_d == 2'd2);
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      unique case (state_d)
         StIdle:                      ;
         StStart: begin
            scl_d = (phase_d != 2'd3);
            sda_d = (phase_d < 2'd2);
         end
         StAddr, StWrite: begin
            scl_d = scl_bit;
            sda_d = shift_d[7];
         end
         StAddrAck, StWriteAck, StRead: scl_d = scl_bit;
         StReadAck: begin
            scl_d = scl_bit;
            sda_d = (rcnt_d == '0);
         end
         StWaitWr: scl_d = 1'b0;
         StRstart: begin
            scl_d = scl_bit;
            sda_d = (phase_d < 2'd2);
         end
         StStop: begin
            scl_d = (phase_d != 2'd0);
            sda_d = (phase_d >= 2'd2);
         end
         default:                     ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         qcnt_q     <= '0;
         phase_q    <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         rd_q       <= 1'b0;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         sample_q   <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         sample_q   <= sample_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         done_q     <= done_d;
         nack_q     <= nack_d;
         scl_q      <= scl_d;
         sda_q      <= sda_d;
         scl_sync_q <= {scl_sync_q[0], i_scl};
         sda_sync_q <= {sda_sync_q[0], i_sda};
      end
   end

   assign o_wready = (state_q == StWaitWr);
   assign o_rdata  = rdata_q;
   assign o_rvalid = rvalid_q;
   assign o_busy   = (state_q != StIdle);
   assign o_done   = done_q;
   assign o_nack   = nack_q;
   assign o_scl    = scl_q;
   assign o_sda    = sda_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: bus-level target model at address 0x48 plus a transaction-level
// reference of the expected bus bytes, read data, handshakes and status.
`timescale 1ns/1ps
module tb_i2c_reg_master;

   localparam int unsigned LenW    = 4;
   localparam int unsigned QDiv    = 4;
   localparam logic [6:0]  TgtAddr = 7'h48;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [6:0]      addr = '0;
   logic [LenW-1:0] wlen = '0;
   logic [LenW-1:0] rlen = '0;
   logic [7:0]      wdata = '0;
   logic            wvalid = 1'b0;
   logic            wready, rvalid, busy, done, nack, scl_o, sda_o;
   logic [7:0]      rdata;
   logic            tgt_scl = 1'b1;
   logic            tgt_sda = 1'b1;
   logic            bus_scl, bus_sda;

   assign bus_scl = scl_o & tgt_scl;
   assign bus_sda = sda_o & tgt_sda;

   i2c_reg_master #(
      .CLK_FREQ(1_600_000),
      .I2C_FREQ(100_000),
      .LEN_W   (LenW)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_addr  (addr),
      .i_wlen  (wlen),
      .i_rlen  (rlen),
      .i_wdata (wdata),
      .i_wvalid(wvalid),
      .o_wready(wready),
      .o_rdata (rdata),
      .o_rvalid(rvalid),
      .o_busy  (busy),
      .o_done  (done),
      .o_nack  (nack),
      .o_scl   (scl_o),
      .o_sda   (sda_o),
      .i_scl   (bus_scl),
      .i_sda   (bus_sda)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Target / bus monitor: logs every 9-bit frame as {byte, ack}.
   logic [8:0] mon_q[$];
   logic [7:0] tgt_rd_q[$];
   int         n_start, n_stop, bitn, byte_idx, frozen_bad;
   bit         rd_mode, tx_on, stretch_armed, stretch_meas, stretch_done, rel_seen;
   logic [8:0] sh;
   logic [7:0] tx_byte;
   time        t_rise, high_ns;

   always @(negedge bus_sda) if (bus_scl === 1'b1) begin
      n_start++;
      bitn = 0; byte_idx = 0; rd_mode = 0; tx_on = 0;
   end

   always @(posedge bus_sda) if (bus_scl === 1'b1) begin
      n_stop++;
      bitn = 0; tx_on = 0;
   end

   always @(posedge bus_scl) begin
      t_rise = $time;
      sh = {sh[7:0], bus_sda};
      bitn++;
      if (bitn == 9) begin
         mon_q.push_back(sh);
         bitn = 0;
         if (byte_idx == 0) begin
            rd_mode = sh[1];
            tx_on   = (sh[8:2] == TgtAddr) && sh[1] && !sh[0];
         end else if (rd_mode) begin
            tx_on = !sh[0];
         end
         byte_idx++;
      end
   end

   always @(negedge bus_scl) begin
      if (stretch_meas) begin
         high_ns = $time - t_rise;
         stretch_meas = 0;
      end
      #1;
      if (bitn == 8) begin
         if (byte_idx == 0) tgt_sda = !(sh[7:1] == TgtAddr);
         else               tgt_sda = rd_mode;
      end else if (tx_on) begin
         if (bitn == 0) begin
            tx_byte = 8'hFF;
            if (tgt_rd_q.size() > 0) tx_byte = tgt_rd_q.pop_front();
         end
         tgt_sda = tx_byte[7-bitn];
         if (bitn == 4 && stretch_armed) begin
            stretch_armed = 0; rel_seen = 0; frozen_bad = 0;
            tgt_scl = 1'b0;
            repeat (500) begin
               @(negedge clk);
               if (scl_o) rel_seen = 1;
               else if (rel_seen) frozen_bad++;
            end
            tgt_scl = 1'b1;
            stretch_meas = 1; stretch_done = 1;
         end
      end else begin
         tgt_sda = 1'b1;
      end
   end

   logic [7:0] wsrc[$];
   logic [7:0] rsrc[$];

   task automatic fill_random(input int wl, input int rl);
      wsrc.delete(); rsrc.delete();
      for (int i = 0; i < wl; i++) wsrc.push_back(8'($urandom));
      for (int i = 0; i < rl; i++) rsrc.push_back(8'($urandom));
   endtask

   task automatic run_txn(input logic [6:0] a, input int wl, input int rl, input bit stretch,
                          input int abort_hs);
      logic [7:0] wq[$];
      logic [7:0] got_r[$];
      logic [8:0] exp_log[$];
      bit         present, rd_first;
      int         hs, dones, wr_hi, cyc, abort_cnt, exp_starts;
      present  = (a == TgtAddr);
      rd_first = (wl == 0) && (rl != 0);
      wq = wsrc; tgt_rd_q = rsrc; got_r.delete();
      mon_q.delete(); n_start = 0; n_stop = 0; tgt_sda = 1'b1;
      stretch_armed = stretch; stretch_done = 0; high_ns = 0;
      hs = 0; dones = 0; wr_hi = 0; cyc = 0; abort_cnt = 0;

      @(negedge clk);
      addr = a; wlen = LenW'(wl); rlen = LenW'(rl); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      addr = 7'($urandom); wlen = LenW'($urandom); rlen = LenW'($urandom);
      while (dones == 0 && cyc < 6000) begin
         wvalid = (wq.size() > 0) && ($urandom_range(0, 2) != 0);
         wdata  = wvalid ? wq[0] : 8'($urandom);
         if (wready) wr_hi++;
         if (wvalid && wready) begin
            void'(wq.pop_front());
            hs++;
         end
         if (rvalid) got_r.push_back(rdata);
         if (done) begin
            dones++;
            check("busy_clear_at_done", busy, 1'b0);
         end
         start = (cyc == 40);
         if (abort_hs != 0 && hs == abort_hs) begin
            abort_cnt++;
            if (abort_cnt == 20) break;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; wvalid = 1'b0;

      if (abort_hs != 0) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("abort_scl", scl_o, 1'b1);
         check("abort_sda", sda_o, 1'b1);
         check("abort_busy", busy, 1'b0);
         check("abort_wready", wready, 1'b0);
         check("abort_done", done, 1'b0);
         check("abort_rdata", rdata, 8'h00);
         repeat (30) @(negedge clk);
         return;
      end

      check("done_seen", dones, 1);
      repeat (3) @(negedge clk);
      check("done_single", done, 1'b0);

      // Reference: frames the bus must carry for this request.
      exp_starts = 1;
      exp_log.push_back({a, rd_first, !present});
      if (present) begin
         if (!rd_first) begin
            foreach (wsrc[i]) exp_log.push_back({wsrc[i], 1'b0});
            if (rl != 0) begin
               exp_starts = 2;
               exp_log.push_back({a, 1'b1, 1'b0});
            end
         end
         for (int i = 0; i < rl; i++) exp_log.push_back({rsrc[i], i == rl - 1});
      end

      check("n_start", n_start, exp_starts);
      check("n_stop", n_stop, 1);
      check("frame_count", mon_q.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < mon_q.size(); i++)
         check($sformatf("frame[%0d]", i), mon_q[i], exp_log[i]);
      check("handshakes", hs, present ? wl : 0);
      if (!present) check("wready_never", wr_hi, 0);
      check("rvalid_count", got_r.size(), present ? rl : 0);
      for (int i = 0; i < got_r.size() && i < rsrc.size(); i++)
         check($sformatf("rdata[%0d]", i), got_r[i], rsrc[i]);
      check("nack", nack, !present);
      if (stretch) begin
         check("stretch_hit", stretch_done, 1'b1);
         check("stretch_frozen", frozen_bad, 0);
         check("stretch_released", rel_seen, 1'b1);
         check("scl_high_quarter", high_ns >= 10 * QDiv, 1'b1);
      end
      repeat (20) @(negedge clk);
      check("nack_held", nack, !present);
      check("idle_scl", scl_o, 1'b1);
   endtask

   initial begin
      logic [6:0] ra;
      int         rwl, rrl;
      repeat (3) @(negedge clk);
      check("rst_scl", scl_o, 1'b1);
      check("rst_sda", sda_o, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_wready", wready, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_nack", nack, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      rst = 1'b0;

      wsrc = '{8'h01, 8'h84, 8'h83}; rsrc.delete();
      run_txn(7'h48, 3, 0, 0, 0);

      wsrc = '{8'h00}; rsrc = '{8'h7F, 8'hF0};
      run_txn(7'h48, 1, 2, 0, 0);

      fill_random(2, 0);
      run_txn(7'h22, 2, 0, 0, 0);

      fill_random(0, 2);
      run_txn(7'h48, 0, 2, 1, 0);

      for (int k = 0; k < 6; k++) begin
         rwl = $urandom_range(0, 3);
         rrl = $urandom_range(0, 3);
         ra  = ($urandom_range(0, 3) != 0) ? TgtAddr : 7'($urandom_range(0, 127));
         fill_random(rwl, rrl);
         run_txn(ra, rwl, rrl, 0, 0);
      end

      fill_random(3, 0);
      run_txn(7'h48, 3, 0, 0, 2);
      fill_random(0, 0);
      run_txn(7'h48, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
